// File: rtl/ahb_pkg.sv
// Shared AHB encodings used by the master interface and the arbiter FSM.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001,
    HBURST_WRAP4  = 3'b010,
    HBURST_INCR4  = 3'b011,
    HBURST_WRAP8  = 3'b100,
    HBURST_INCR8  = 3'b101,
    HBURST_WRAP16 = 3'b110,
    HBURST_INCR16 = 3'b111
  } hburst_e;

  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_GRANT = 2'd1;
  localparam logic [1:0] ARB_DRAIN = 2'd2;

endpackage

// File: rtl/ahb_master_arbiter_rr_priority_pick.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping modulo N.
module rr_priority_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  sel,
  output logic [PW-1:0] idx,
  output logic          any
);

  logic [PW:0]   sum;
  logic [PW-1:0] pos;

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    sel = '0;
    idx = '0;
    sum = '0;
    pos = '0;
    for (int off = N - 1; off >= 0; off--) begin
      sum = {1'b0, ptr} + (PW + 1)'(off);
      if (sum >= (PW + 1)'(N)) begin
        sum = sum - (PW + 1)'(N);
      end
      pos = sum[PW-1:0];
      if (req[pos]) begin
        sel      = '0;
        sel[pos] = 1'b1;
        idx      = pos;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/ahb_master_arbiter.sv
// Round-robin arbiter sharing one AHB master interface among REQ_NUM requesters;
// a grant is held until the requester ends its sequence and the interface drains.
module ahb_master_arbiter
  import ahb_pkg::*;
#(
  parameter int REQ_NUM        = 4,
  parameter int AHB_ADDR_WIDTH = 32,
  parameter int AHB_DATA_WIDTH = 32,
  parameter int DRAIN_TIMEOUT  = 64
) (
  input  logic                                  ahb_clk_in,
  input  logic                                  ahb_rst_in,
  input  logic [REQ_NUM-1:0]                    req_valid_in,
  input  logic [REQ_NUM-1:0]                    req_end_in,
  input  logic [REQ_NUM*AHB_ADDR_WIDTH-1:0]     req_addr_in,
  input  logic [REQ_NUM*3-1:0]                  req_burst_in,
  input  logic [REQ_NUM*3-1:0]                  req_size_in,
  input  logic [REQ_NUM*4-1:0]                  req_prot_in,
  input  logic [REQ_NUM*(AHB_DATA_WIDTH/8)-1:0] req_strb_in,
  input  logic [REQ_NUM*AHB_DATA_WIDTH-1:0]     req_wdata_in,
  input  logic [REQ_NUM-1:0]                    req_write_in,
  output logic [REQ_NUM-1:0]                    req_grant_out,
  output logic [REQ_NUM-1:0]                    req_ready_out,
  output logic [REQ_NUM-1:0]                    req_error_out,
  output logic [AHB_DATA_WIDTH-1:0]             req_rdata_out,
  output logic                                  mst_valid_out,
  output logic                                  mst_end_out,
  output logic                                  mst_write_out,
  output logic [AHB_ADDR_WIDTH-1:0]             mst_addr_out,
  output logic [2:0]                            mst_burst_out,
  output logic [2:0]                            mst_size_out,
  output logic [3:0]                            mst_prot_out,
  output logic [AHB_DATA_WIDTH/8-1:0]           mst_strb_out,
  output logic [AHB_DATA_WIDTH-1:0]             mst_wdata_out,
  input  logic                                  mst_ready_in,
  input  logic                                  mst_error_in,
  input  logic [AHB_DATA_WIDTH-1:0]             mst_rdata_in,
  input  logic                                  mst_busy_in,
  output logic                                  arb_timeout_out
);

  localparam int SW = AHB_DATA_WIDTH / 8;
  localparam int PW = $clog2(REQ_NUM);
  localparam int CW = $clog2(DRAIN_TIMEOUT);

  logic [AHB_ADDR_WIDTH-1:0] addr_arr  [REQ_NUM];
  logic [2:0]                burst_arr [REQ_NUM];
  logic [2:0]                size_arr  [REQ_NUM];
  logic [3:0]                prot_arr  [REQ_NUM];
  logic [SW-1:0]             strb_arr  [REQ_NUM];
  logic [AHB_DATA_WIDTH-1:0] wdata_arr [REQ_NUM];

  for (genvar gi = 0; gi < REQ_NUM; gi++) begin : g_slice
    assign addr_arr[gi]  = req_addr_in[gi*AHB_ADDR_WIDTH +: AHB_ADDR_WIDTH];
    assign burst_arr[gi] = req_burst_in[gi*3 +: 3];
    assign size_arr[gi]  = req_size_in[gi*3 +: 3];
    assign prot_arr[gi]  = req_prot_in[gi*4 +: 4];
    assign strb_arr[gi]  = req_strb_in[gi*SW +: SW];
    assign wdata_arr[gi] = req_wdata_in[gi*AHB_DATA_WIDTH +: AHB_DATA_WIDTH];
  end

  logic [1:0]                state_reg;
  logic [REQ_NUM-1:0]        grant_reg;
  logic [PW-1:0]             gidx_reg;
  logic [PW-1:0]             ptr_reg;
  logic [CW-1:0]             drain_cnt_reg;
  logic                      timeout_reg;
  logic                      lat_write_reg;
  logic [AHB_ADDR_WIDTH-1:0] lat_addr_reg;
  logic [2:0]                lat_burst_reg;
  logic [2:0]                lat_size_reg;
  logic [3:0]                lat_prot_reg;
  logic [SW-1:0]             lat_strb_reg;
  logic [AHB_DATA_WIDTH-1:0] lat_wdata_reg;

  logic [REQ_NUM-1:0] pick_sel;
  logic [PW-1:0]      pick_idx;
  logic               pick_any;

  rr_priority_pick #(
    .N  (REQ_NUM),
    .PW (PW)
  ) u_pick (
    .req (req_valid_in),
    .ptr (ptr_reg),
    .sel (pick_sel),
    .idx (pick_idx),
    .any (pick_any)
  );

  logic          g_valid;
  logic          g_end;
  logic          seq_done;
  logic          drain_hit;
  logic          drain_exit;
  logic [PW-1:0] ptr_next;

  // A granted requester dropping valid is treated as an implicit end of sequence.
  assign g_valid    = req_valid_in[gidx_reg];
  assign g_end      = req_end_in[gidx_reg];
  assign seq_done   = !g_valid || g_end;
  assign drain_hit  = (drain_cnt_reg == CW'(DRAIN_TIMEOUT - 1));
  assign drain_exit = !mst_busy_in || drain_hit;
  assign ptr_next   = (gidx_reg == PW'(REQ_NUM - 1)) ? '0 : gidx_reg + PW'(1);

  always_ff @(posedge ahb_clk_in) begin
    if (ahb_rst_in) begin
      state_reg     <= ARB_IDLE;
      grant_reg     <= '0;
      gidx_reg      <= '0;
      ptr_reg       <= '0;
      drain_cnt_reg <= '0;
      timeout_reg   <= 1'b0;
      lat_write_reg <= 1'b0;
      lat_addr_reg  <= '0;
      lat_burst_reg <= '0;
      lat_size_reg  <= '0;
      lat_prot_reg  <= '0;
      lat_strb_reg  <= '0;
      lat_wdata_reg <= '0;
    end else begin
      timeout_reg <= 1'b0;
      case (state_reg)
        ARB_IDLE: begin
          if (pick_any) begin
            grant_reg <= pick_sel;
            gidx_reg  <= pick_idx;
            state_reg <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (seq_done) begin
            lat_write_reg <= req_write_in[gidx_reg];
            lat_addr_reg  <= addr_arr[gidx_reg];
            lat_burst_reg <= burst_arr[gidx_reg];
            lat_size_reg  <= size_arr[gidx_reg];
            lat_prot_reg  <= prot_arr[gidx_reg];
            lat_strb_reg  <= strb_arr[gidx_reg];
            lat_wdata_reg <= wdata_arr[gidx_reg];
            drain_cnt_reg <= '0;
            state_reg     <= ARB_DRAIN;
          end
        end
        ARB_DRAIN: begin
          if (drain_exit) begin
            grant_reg   <= '0;
            ptr_reg     <= ptr_next;
            state_reg   <= ARB_IDLE;
            // Busy still high here means only the counter released us.
            timeout_reg <= mst_busy_in;
          end else begin
            drain_cnt_reg <= drain_cnt_reg + CW'(1);
          end
        end
        default: state_reg <= ARB_IDLE;
      endcase
    end
  end

  always_comb begin
    mst_valid_out = 1'b0;
    mst_end_out   = 1'b0;
    mst_write_out = 1'b0;
    mst_addr_out  = '0;
    mst_burst_out = '0;
    mst_size_out  = '0;
    mst_prot_out  = '0;
    mst_strb_out  = '0;
    mst_wdata_out = '0;
    req_ready_out = '0;
    req_error_out = '0;
    req_rdata_out = '0;
    case (state_reg)
      ARB_GRANT: begin
        mst_valid_out = g_valid;
        mst_end_out   = g_end;
        mst_write_out = req_write_in[gidx_reg];
        mst_addr_out  = addr_arr[gidx_reg];
        mst_burst_out = burst_arr[gidx_reg];
        mst_size_out  = size_arr[gidx_reg];
        mst_prot_out  = prot_arr[gidx_reg];
        mst_strb_out  = strb_arr[gidx_reg];
        mst_wdata_out = wdata_arr[gidx_reg];
      end
      ARB_DRAIN: begin
        mst_valid_out = 1'b1;
        mst_end_out   = 1'b1;
        mst_write_out = lat_write_reg;
        mst_addr_out  = lat_addr_reg;
        mst_burst_out = lat_burst_reg;
        mst_size_out  = lat_size_reg;
        mst_prot_out  = lat_prot_reg;
        mst_strb_out  = lat_strb_reg;
        mst_wdata_out = lat_wdata_reg;
      end
      default: ;
    endcase
    if (state_reg == ARB_GRANT || state_reg == ARB_DRAIN) begin
      req_ready_out[gidx_reg] = mst_ready_in;
      req_error_out[gidx_reg] = mst_error_in;
      req_rdata_out           = mst_rdata_in;
    end
  end

  assign req_grant_out   = grant_reg;
  assign arb_timeout_out = timeout_reg;

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Self-checking bench for ahb_master_arbiter: directed scenarios plus random traffic
// compared against a transaction-level ownership model.
module tb_ahb_master_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int T  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N-1:0]    valid, req_end, write;
  logic [N*AW-1:0] addr;
  logic [N*3-1:0]  burst, size;
  logic [N*4-1:0]  prot, strb;
  logic [N*DW-1:0] wdata;
  logic            mready, merror, mbusy;
  logic [DW-1:0]   mrdata;

  logic [N-1:0]    grant, rready, rerror;
  logic [DW-1:0]   rdata;
  logic            mvalid, mend, mwrite, tout;
  logic [AW-1:0]   maddr;
  logic [2:0]      mburst, msize;
  logic [3:0]      mprot, mstrb;
  logic [DW-1:0]   mwdata;

  ahb_master_arbiter #(
    .REQ_NUM(N), .AHB_ADDR_WIDTH(AW), .AHB_DATA_WIDTH(DW), .DRAIN_TIMEOUT(T)
  ) dut (
    .ahb_clk_in(clk), .ahb_rst_in(rst),
    .req_valid_in(valid), .req_end_in(req_end), .req_addr_in(addr),
    .req_burst_in(burst), .req_size_in(size), .req_prot_in(prot),
    .req_strb_in(strb), .req_wdata_in(wdata), .req_write_in(write),
    .req_grant_out(grant), .req_ready_out(rready), .req_error_out(rerror),
    .req_rdata_out(rdata),
    .mst_valid_out(mvalid), .mst_end_out(mend), .mst_write_out(mwrite),
    .mst_addr_out(maddr), .mst_burst_out(mburst), .mst_size_out(msize),
    .mst_prot_out(mprot), .mst_strb_out(mstrb), .mst_wdata_out(mwdata),
    .mst_ready_in(mready), .mst_error_in(merror), .mst_rdata_in(mrdata),
    .mst_busy_in(mbusy), .arb_timeout_out(tout)
  );

  int checks = 0;
  int passed = 0;

  // Reference model: who owns the interface, whether it is draining, and for how long.
  int   m_owner;
  bit   m_drain;
  int   m_age;
  int   m_ptr;
  bit   m_tout;
  logic [80:0] m_held;

  logic [N-1:0]  exp_grant;
  logic [80:0]   exp_mst;
  logic [39:0]   exp_resp;
  logic          exp_tout;

  function automatic logic [80:0] obs_mst();
    return {mvalid, mend, mwrite, maddr, mburst, msize, mprot, mstrb, mwdata};
  endfunction

  function automatic logic [39:0] obs_resp();
    return {rready, rerror, rdata};
  endfunction

  function automatic logic [80:0] req_fields(int o);
    return {valid[o], req_end[o], write[o], addr[o*AW +: AW], burst[o*3 +: 3],
            size[o*3 +: 3], prot[o*4 +: 4], strb[o*4 +: 4], wdata[o*DW +: DW]};
  endfunction

  task automatic model_comb();
    logic [N-1:0] r, e;
    exp_grant = '0;
    exp_mst   = '0;
    exp_resp  = '0;
    exp_tout  = m_tout;
    if (m_owner >= 0) begin
      r = '0;
      e = '0;
      r[m_owner] = mready;
      e[m_owner] = merror;
      exp_grant[m_owner] = 1'b1;
      exp_resp = {r, e, mrdata};
      if (!m_drain) exp_mst = req_fields(m_owner);
      else          exp_mst = {2'b11, m_held[78:0]};
    end
  endtask

  task automatic model_tick();
    m_tout = 1'b0;
    if (rst) begin
      m_owner = -1; m_drain = 1'b0; m_ptr = 0; m_age = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (valid[c]) begin
          m_owner = c; m_drain = 1'b0;
          break;
        end
      end
    end else if (!m_drain) begin
      if (!valid[m_owner] || req_end[m_owner]) begin
        m_held  = req_fields(m_owner);
        m_drain = 1'b1;
        m_age   = 0;
      end
    end else if (!mbusy || m_age == T - 1) begin
      m_tout  = mbusy;
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
      m_drain = 1'b0;
    end else begin
      m_age++;
    end
  endtask

  task automatic tick();
    model_tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    valid = '0; req_end = '0; write = '0; addr = '0; burst = '0; size = '0;
    prot = '0; strb = '0; wdata = '0; mready = 1'b0; merror = 1'b0;
    mbusy = 1'b0; mrdata = '0;
  endtask

  task automatic reset_dut();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    valid = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      checks++; if (grant !== 4'b0000) $display("FAIL reset_grant[%0d]: got %b want 0000", i, grant); else passed++;
      checks++; if (obs_mst() !== 81'd0) $display("FAIL reset_mst[%0d]: got %h want 0", i, obs_mst()); else passed++;
      checks++; if ({obs_resp(), tout} !== 41'd0) $display("FAIL reset_resp[%0d]: got %h want 0", i, {obs_resp(), tout}); else passed++;
    end
    rst = 1'b0;
    tick();
    #1;
    checks++; if (grant !== 4'b0001) $display("FAIL reset_first_grant: got %b want 0001", grant); else passed++;
    checks++; if (mvalid !== 1'b1) $display("FAIL reset_first_valid: got %b want 1", mvalid); else passed++;
  endtask

  task automatic test_round_robin();
    logic [N-1:0] seen[$];
    logic [N-1:0] exp_rr[3];
    logic [N-1:0] prev;
    exp_rr = '{4'b0010, 4'b1000, 4'b0010};
    reset_dut();
    valid = 4'b1010;
    req_end = 4'b1010;
    prev = '0;
    for (int c = 0; c < 14; c++) begin
      #1;
      if (grant != 0 && prev == 0) begin
        seen.push_back(grant);
        $display("rr txn: grant %b", grant);
      end
      prev = grant;
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= seen.size()) $display("FAIL rr_order[%0d]: got none want %b", i, exp_rr[i]);
      else if (seen[i] !== exp_rr[i]) $display("FAIL rr_order[%0d]: got %b want %b", i, seen[i], exp_rr[i]);
      else passed++;
    end
  endtask

  task automatic test_routing();
    logic [DW-1:0] rd;
    reset_dut();
    for (int i = 0; i < N; i++) begin
      addr[i*AW +: AW]  = $urandom;
      wdata[i*DW +: DW] = $urandom;
    end
    valid = 4'b0100;
    write = 4'b0100;
    addr[2*AW +: AW]  = 32'h100;
    wdata[2*DW +: DW] = 32'hDEADBEEF;
    tick();
    #1;
    $display("route txn: grant %b addr %h wdata %h", grant, maddr, mwdata);
    checks++; if (grant !== 4'b0100) $display("FAIL route_grant: got %b want 0100", grant); else passed++;
    checks++; if (maddr !== 32'h100) $display("FAIL route_addr: got %h want 00000100", maddr); else passed++;
    checks++; if (mwdata !== 32'hDEADBEEF) $display("FAIL route_wdata: got %h want deadbeef", mwdata); else passed++;
    checks++; if ({mvalid, mwrite} !== 2'b11) $display("FAIL route_ctrl: got %b want 11", {mvalid, mwrite}); else passed++;
    rd = $urandom;
    mrdata = rd;
    mready = 1'b1;
    #1;
    checks++; if (rready !== 4'b0100) $display("FAIL route_ready: got %b want 0100", rready); else passed++;
    checks++; if (rdata !== rd) $display("FAIL route_rdata: got %h want %h", rdata, rd); else passed++;
    mready = 1'b0;
    merror = 1'b1;
    #1;
    checks++; if ({rerror, rready} !== 8'b0100_0000) $display("FAIL route_error: got %b want 01000000", {rerror, rready}); else passed++;
    merror = 1'b0;
    valid = '0;
    tick();
    tick();
  endtask

  task automatic test_drain();
    reset_dut();
    valid = 4'b0011;
    tick();
    req_end = 4'b0001;
    tick();
    valid = 4'b0010;
    req_end = '0;
    for (int j = 1; j <= 4; j++) begin
      mbusy = (j < 4);
      #1;
      checks++; if ({mend, grant} !== 5'b1_0001) $display("FAIL drain_hold[%0d]: got %b want 10001", j, {mend, grant}); else passed++;
      tick();
    end
    mbusy = 1'b0;
    #1;
    checks++; if (grant !== 4'b0000) $display("FAIL drain_release: got %b want 0000", grant); else passed++;
    tick();
    #1;
    checks++; if (grant !== 4'b0010) $display("FAIL drain_next_grant: got %b want 0010", grant); else passed++;
  endtask

  task automatic test_timeout();
    int pulses, pulse_at;
    reset_dut();
    valid = 4'b0001;
    req_end = 4'b0001;
    mbusy = 1'b1;
    tick();
    tick();
    valid = '0;
    req_end = '0;
    pulses = 0;
    pulse_at = -1;
    for (int off = 0; off < 16; off++) begin
      #1;
      if (tout === 1'b1) begin
        pulses++;
        pulse_at = off;
      end
      if (off == T) begin
        checks++; if ({grant, mvalid} !== 5'b0) $display("FAIL timeout_idle: got %b want 00000", {grant, mvalid}); else passed++;
      end
      tick();
    end
    checks++; if (pulses !== 1) $display("FAIL timeout_count: got %0d want 1", pulses); else passed++;
    checks++; if (pulse_at !== T) $display("FAIL timeout_cycle: got %0d want %0d", pulse_at, T); else passed++;
    mbusy = 1'b0;
  endtask

  task automatic test_mid_reset();
    reset_dut();
    valid = 4'b0010;
    tick();
    tick();
    tick();
    #1;
    checks++; if (grant !== 4'b0010) $display("FAIL midrst_pre: got %b want 0010", grant); else passed++;
    rst = 1'b1;
    valid = 4'b0011;
    tick();
    rst = 1'b0;
    #1;
    checks++; if ({grant, obs_mst(), obs_resp(), tout} !== 126'd0) $display("FAIL midrst_zero: got %h want 0", {grant, obs_mst(), obs_resp(), tout}); else passed++;
    tick();
    #1;
    checks++; if (grant !== 4'b0001) $display("FAIL midrst_ptr: got %b want 0001", grant); else passed++;
  endtask

  task automatic test_random();
    logic [N-1:0] prev;
    reset_dut();
    prev = '0;
    for (int c = 0; c < 400; c++) begin
      rst     = ($urandom_range(0, 99) == 0);
      valid   = N'($urandom);
      for (int i = 0; i < N; i++) req_end[i] = ($urandom_range(0, 3) == 0);
      write   = N'($urandom);
      for (int i = 0; i < N; i++) begin
        addr[i*AW +: AW]  = $urandom;
        wdata[i*DW +: DW] = $urandom;
      end
      burst  = 12'($urandom); size = 12'($urandom);
      prot   = 16'($urandom); strb = 16'($urandom);
      mbusy  = ($urandom_range(0, 9) < 7);
      mready = 1'($urandom); merror = 1'($urandom);
      mrdata = $urandom;
      #1;
      model_comb();
      if (grant != 0 && prev == 0) $display("rand txn: cycle %0d grant %b", c, grant);
      prev = grant;
      checks++; if (grant !== exp_grant) $display("FAIL rand_grant@%0d: got %b want %b", c, grant, exp_grant); else passed++;
      checks++; if (obs_mst() !== exp_mst) $display("FAIL rand_mst@%0d: got %h want %h", c, obs_mst(), exp_mst); else passed++;
      checks++; if (obs_resp() !== exp_resp) $display("FAIL rand_resp@%0d: got %h want %h", c, obs_resp(), exp_resp); else passed++;
      checks++; if (tout !== exp_tout) $display("FAIL rand_timeout@%0d: got %b want %b", c, tout, exp_tout); else passed++;
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    m_owner = -1; m_drain = 1'b0; m_age = 0; m_ptr = 0; m_tout = 1'b0; m_held = '0;
    clear_inputs();
    rst = 1'b1;
    test_reset();
    test_round_robin();
    test_routing();
    test_drain();
    test_timeout();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
